// File: rtl/exibidor_bcd_mux.sv
// exibidor_bcd_mux: converts each finished binary count to BCD (sequential double-dabble) and drives
// a multiplexed active-low 7-segment display. Define BLANK_ZERO_EN to suppress leading zero digits.
module exibidor_bcd_mux #(
    parameter int IN_W        = 20,
    parameter int N_DIGITS    = 6,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_W-1:0]     contagem,
    input  logic                valida,
    input  logic [3:0]          seletor,
    output logic                ocupado,
    output logic                overflow,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [N_DIGITS-1:0] an
);

    localparam int BCD_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int REF_W = $clog2(REFRESH_DIV);

    localparam longint           MAX_DISP   = (longint'(10) ** N_DIGITS) - 1;
    localparam logic [63:0]      MAX_DISP_U = 64'(MAX_DISP);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(IN_W - 1);
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        CARREGA  = 2'd2
    } estado_t;

    estado_t            state_q, state_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcdAdj;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic               ovfPend_q, ovfPend_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               dash_q, dash_d;
    logic               overflow_q, overflow_d;
    logic               mostra_q, mostra_d;
    logic               ocupado_q;
    logic [REF_W-1:0]   refCnt_q, refCnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [N_DIGITS-1:0] an_q, an_d;

    logic [63:0]        contagemExt;
    logic               refWrap;
    logic [3:0]         curDigit;
    logic               dpValid;
    int                 dpPos;
    logic               dpHit;
    logic               leadZero;
    logic [N_DIGITS-1:0] blankMask;

    assign contagemExt = 64'(contagem);

    function automatic logic [6:0] segCode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Conversion FSM: capture, IN_W double-dabble steps, then publish to the display registers.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bitCnt_d   = bitCnt_q;
        ovfPend_d  = ovfPend_q;
        disp_d     = disp_q;
        dash_d     = dash_q;
        overflow_d = overflow_q;
        mostra_d   = mostra_q;

        bcdAdj = bcd_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            OCIOSO: begin
                if (valida) begin
                    bin_d     = contagem;
                    bcd_d     = '0;
                    bitCnt_d  = '0;
                    ovfPend_d = (contagemExt > MAX_DISP_U);
                    state_d   = CONVERTE;
                end
            end
            CONVERTE: begin
                {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
                bitCnt_d       = bitCnt_q + CNT_W'(1);
                if (bitCnt_q == LAST_BIT) begin
                    state_d = CARREGA;
                end
            end
            CARREGA: begin
                disp_d     = bcd_q;
                dash_d     = ovfPend_q;
                overflow_d = ovfPend_q;
                mostra_d   = 1'b1;
                state_d    = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

    // Refresh divider and digit scan index; the scan never stops, even while converting.
    always_comb begin
        refWrap  = (refCnt_q == REF_LAST);
        refCnt_d = refWrap ? '0 : refCnt_q + REF_W'(1);
        idx_d    = idx_q;
        if (refWrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Next display outputs from the current scan index; seletor is used live for the decimal point.
    always_comb begin
        curDigit  = disp_q[4*idx_q +: 4];
        dpValid   = (int'(seletor) >= 1) && (int'(seletor) <= N_DIGITS);
        dpPos     = int'(seletor) - 1;
        dpHit     = dpValid && (int'(idx_q) == dpPos);
        leadZero  = 1'b1;
        blankMask = '0;
`ifdef BLANK_ZERO_EN
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            leadZero = leadZero && (disp_q[4*i +: 4] == 4'd0);
            if (leadZero && !(dpValid && (i <= dpPos))) begin
                blankMask[i] = 1'b1;
            end
        end
`endif

        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (mostra_q) begin
            an_d = ~(N_DIGITS'(1) << idx_q);
            dp_d = ~dpHit;
            if (dash_q) begin
                seg_d = 7'h3F;
            end else if (blankMask[idx_q]) begin
                seg_d = 7'h7F;
            end else begin
                seg_d = segCode(curDigit);
            end
        end
    end

    // All state and outputs registered; rst_n is synchronous and wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= OCIOSO;
            bin_q      <= '0;
            bcd_q      <= '0;
            bitCnt_q   <= '0;
            ovfPend_q  <= 1'b0;
            disp_q     <= '0;
            dash_q     <= 1'b0;
            overflow_q <= 1'b0;
            mostra_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            refCnt_q   <= '0;
            idx_q      <= '0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            bitCnt_q   <= bitCnt_d;
            ovfPend_q  <= ovfPend_d;
            disp_q     <= disp_d;
            dash_q     <= dash_d;
            overflow_q <= overflow_d;
            mostra_q   <= mostra_d;
            ocupado_q  <= (state_d != OCIOSO);
            refCnt_q   <= refCnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign ocupado  = ocupado_q;
    assign overflow = overflow_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;

endmodule
